// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared types and constants for the instruction loader
// Contents: loader state enum, bytes per instruction word, byte-index width.
package instr_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE,
    ERR
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/instr_loader_packer.sv
// rtl/instr_loader_packer.sv - little-endian byte-to-word assembler
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr_i        restart assembly at byte 0 (start of a new load)
//   valid_i      a byte is being accepted this cycle
//   byte_i       the accepted byte
//   word_o       assembled word including byte_i (meaningful with word_done_o)
//   word_done_o  byte_i completes the current word
module instr_loader_packer
  import instr_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr_i,
  input  logic                        valid_i,
  input  logic [7:0]                  byte_i,
  output logic [8*BYTES_PER_WORD-1:0] word_o,
  output logic                        word_done_o
);

  logic [BYTE_IDX_W-1:0]             idx_q, idx_d;
  // Only the first three bytes need storage; the fourth arrives on byte_i.
  logic [8*(BYTES_PER_WORD-1)-1:0]   sh_q, sh_d;

  // Bytes shift in from the top, so after four bytes the first one sits in [7:0].
  assign word_o      = {byte_i, sh_q};
  assign word_done_o = valid_i && (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

  always_comb begin
    idx_d = idx_q;
    sh_d  = sh_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (valid_i) begin
      sh_d  = word_o[8*BYTES_PER_WORD-1:8];
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      sh_q  <= '0;
    end else begin
      idx_q <= idx_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - boot-time instruction-memory loader from a byte stream
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte, ERR state).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, word_count     begin a load of word_count words (clamped to DEPTH)
//   in_valid/in_data      byte stream in, in_ready out
//   wr_en/wr_addr/wr_data instruction-memory write port
//   core_rst_n            core reset, released one cycle after done
//   busy, done, err       load status
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 2 ** ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH:0]    word_count,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [INSTR_WIDTH-1:0] wr_data,
  output logic                   core_rst_n,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int            CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d, widx_q, widx_d, count_clamped;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [INSTR_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                   in_ready_q, in_ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   core_rst_n_q, core_rst_n_d;
  logic                   accept, restart, pk_clr, pk_valid, pk_done;
  logic [INSTR_WIDTH-1:0] pk_word;

`ifdef LOADER_CHECKSUM_EN
  logic       ck_q, ck_d;       // next accepted byte is the checksum
  logic [7:0] csum_q, csum_d;
  logic       err_q, err_d;
  assign pk_valid = accept && !ck_q;
  assign err      = err_q;
`else
  assign pk_valid = accept;
  assign err      = 1'b0;
`endif

  assign accept        = in_valid && in_ready_q;
  assign restart       = start && (state_q == DONE);
  assign count_clamped = (word_count > DEPTH_C) ? DEPTH_C : word_count;

  instr_loader_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (pk_clr),
    .valid_i    (pk_valid),
    .byte_i     (in_data),
    .word_o     (pk_word),
    .word_done_o(pk_done)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    widx_d    = widx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    pk_clr    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    ck_d      = ck_q;
    csum_d    = csum_q;
`endif
    case (state_q)
      LOAD: begin
        // start is deliberately ignored here.
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          if (ck_q) begin
            state_d = (in_data == csum_q) ? DONE : ERR;
            ck_d    = 1'b0;
          end else begin
            csum_d = csum_q ^ in_data;
`endif
            if (pk_done) begin
              wr_en_d   = 1'b1;
              wr_addr_d = widx_q[ADDR_WIDTH-1:0];
              wr_data_d = pk_word;
              widx_d    = widx_q + CW'(1);
              if (widx_d == count_q) begin
`ifdef LOADER_CHECKSUM_EN
                ck_d = 1'b1;
`else
                state_d = DONE;
`endif
              end
            end
`ifdef LOADER_CHECKSUM_EN
          end
`endif
        end
      end
      default: begin
        // IDLE, DONE and ERR all (re)start a load on start.
        if (start) begin
          count_d = count_clamped;
          widx_d  = '0;
          pk_clr  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
          ck_d    = (count_clamped == '0);
          state_d = LOAD;
`else
          state_d = (count_clamped == '0) ? DONE : LOAD;
`endif
        end
      end
    endcase

    // Outputs are registered from the next state. A restart from DONE with a
    // zero count stays in DONE, so done is forced low for that one cycle.
    in_ready_d   = (state_d == LOAD);
    busy_d       = (state_d == LOAD);
    done_d       = (state_d == DONE) && !restart;
    core_rst_n_d = done_q && (state_d == DONE) && !restart;
`ifdef LOADER_CHECKSUM_EN
    err_d        = (state_d == ERR);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      widx_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      core_rst_n_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      ck_q         <= 1'b0;
      csum_q       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      widx_q       <= widx_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      core_rst_n_q <= core_rst_n_d;
`ifdef LOADER_CHECKSUM_EN
      ck_q         <= ck_d;
      csum_q       <= csum_d;
      err_q        <= err_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign core_rst_n = core_rst_n_q;

endmodule
